// File: rtl/ram_read_scheduler.sv
// ram_read_scheduler: shares the single cellular RAM read port between two
// streaming consumers. Channel A walks the low region, channel B the high one.
// Each walker advances by 2 + nivel2 + nivel3 after each completed read and
// wraps back to its first address once it would pass the last legal one.
// Requests are arbitrated round-robin. Each read holds mem_rd/mem_addr for
// LATENCIA cycles, and the word returns with a one-cycle valid strobe.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pedir_a, pedir_b    per-channel read requests (level or pulse)
//   reinicio            rewind both walkers to their region start
//   nivel2, nivel3      stride modifiers, sampled when a read completes
//   mem_dato            RAM read data
//   mem_addr, mem_rd    RAM address / read enable (registered)
//   dato_a, valido_a    last word for A (held) / one-cycle update strobe
//   dato_b, valido_b    last word for B (held) / one-cycle update strobe
//   ocupado             high while a read is in progress
module ram_read_scheduler #(
  parameter logic [25:0] INICIO_A = 26'h000000,
  parameter logic [25:0] FIN_A    = 26'h285FF0,
  parameter logic [25:0] INICIO_B = 26'h800000,
  parameter logic [25:0] FIN_B    = 26'h880000,
  parameter int unsigned LATENCIA = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pedir_a,
  input  logic        pedir_b,
  input  logic        reinicio,
  input  logic        nivel2,
  input  logic        nivel3,
  input  logic [15:0] mem_dato,
  output logic [25:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] dato_a,
  output logic        valido_a,
  output logic [15:0] dato_b,
  output logic        valido_b,
  output logic        ocupado
);

  localparam int unsigned AW = 26;
  localparam int unsigned SW = AW + 1;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic {IDLE, LECTURA} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cont_q, cont_d;
  logic          sel_q, sel_d;
  logic          ultimo_q, ultimo_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  logic [AW-1:0] ptr_a_q, ptr_a_d;
  logic [AW-1:0] ptr_b_q, ptr_b_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [DW-1:0] dato_a_q, dato_a_d;
  logic [DW-1:0] dato_b_q, dato_b_d;
  logic          valido_a_q, valido_a_d;
  logic          valido_b_q, valido_b_d;

  logic [SW-1:0] step;
  logic [SW-1:0] sum_a, sum_b;
  logic [AW-1:0] next_a, next_b;

  // Walker advance: 27-bit sum so a pointer near the top of the address
  // space still compares correctly against FIN.
  always_comb begin
    step   = SW'(2) + SW'(nivel2) + SW'(nivel3);
    sum_a  = {1'b0, ptr_a_q} + step;
    sum_b  = {1'b0, ptr_b_q} + step;
    next_a = (sum_a > {1'b0, FIN_A}) ? INICIO_A : sum_a[AW-1:0];
    next_b = (sum_b > {1'b0, FIN_B}) ? INICIO_B : sum_b[AW-1:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    sel_d      = sel_q;
    ultimo_d   = ultimo_q;
    pend_a_d   = pend_a_q | pedir_a;
    pend_b_d   = pend_b_q | pedir_b;
    ptr_a_d    = ptr_a_q;
    ptr_b_d    = ptr_b_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    valido_a_d = 1'b0;
    valido_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A wins when alone or when B was served last.
        if (pend_a_q && (!pend_b_q || (ultimo_q == CH_B))) begin
          mem_addr_d = ptr_a_q;
          mem_rd_d   = 1'b1;
          cont_d     = CW'(LATENCIA - 1);
          sel_d      = CH_A;
          ultimo_d   = CH_A;
          pend_a_d   = pedir_a;
          state_d    = LECTURA;
        end else if (pend_b_q) begin
          mem_addr_d = ptr_b_q;
          mem_rd_d   = 1'b1;
          cont_d     = CW'(LATENCIA - 1);
          sel_d      = CH_B;
          ultimo_d   = CH_B;
          pend_b_d   = pedir_b;
          state_d    = LECTURA;
        end
      end
      LECTURA: begin
        if (cont_q == '0) begin
          mem_rd_d = 1'b0;
          state_d  = IDLE;
          if (sel_q == CH_A) begin
            dato_a_d   = mem_dato;
            valido_a_d = 1'b1;
            ptr_a_d    = next_a;
          end else begin
            dato_b_d   = mem_dato;
            valido_b_d = 1'b1;
            ptr_b_d    = next_b;
          end
        end else begin
          cont_d = cont_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Rewind overrides any advance of the pointer being served this cycle.
    if (reinicio) begin
      ptr_a_d = INICIO_A;
      ptr_b_d = INICIO_B;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cont_q     <= '0;
      sel_q      <= CH_A;
      ultimo_q   <= CH_B;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      ptr_a_q    <= INICIO_A;
      ptr_b_q    <= INICIO_B;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      valido_a_q <= 1'b0;
      valido_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      sel_q      <= sel_d;
      ultimo_q   <= ultimo_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      ptr_a_q    <= ptr_a_d;
      ptr_b_q    <= ptr_b_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      valido_a_q <= valido_a_d;
      valido_b_q <= valido_b_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign dato_a   = dato_a_q;
  assign valido_a = valido_a_q;
  assign dato_b   = dato_b_q;
  assign valido_b = valido_b_q;
  assign ocupado  = (state_q == LECTURA);

endmodule
